seq_controle: RTL and testbench

- Fetch/decode/execute sequencer for the 8-bit simple processor.
- Owns the program counter, instruction register, accumulator (regA) and memory-data register.
- Drives the 16x8 RAM (rd/we/address/dataIn) and presents operands and opcode to the ULA.
- Replaces manual KEY/switch sequencing; supports free-run and single-instruction step modes for board debug.

---
 rtl/seq_controle_if.sv | 26 ++
 rtl/seq_controle.sv | 159 +++++++++++++++
 tb/tb_seq_controle.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_controle_if.sv
// RAM and ULA connection bundle for the seq_controle sequencer.
// The master side (sequencer) drives addresses, strobes and ULA operands.
interface seq_controle_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] endMem;
  logic              rd;
  logic              we;
  logic [DATA_W-1:0] dataInMem;
  logic [DATA_W-1:0] dataOutMem;
  logic [3:0]        ulaOpcode;
  logic [DATA_W-1:0] ulaA;
  logic [DATA_W-1:0] ulaB;
  logic [DATA_W-1:0] saidaULA;

  modport master (
    output endMem, rd, we, dataInMem, ulaOpcode, ulaA, ulaB,
    input  dataOutMem, saidaULA
  );

  modport slave (
    input  endMem, rd, we, dataInMem, ulaOpcode, ulaA, ulaB,
    output dataOutMem, saidaULA
  );
endinterface

// File: rtl/seq_controle.sv
// Fetch/decode/execute sequencer for the 8-bit simple processor: owns pc, ir,
// accumulator and memory-data register, and drives the RAM and the ULA.
module seq_controle #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              run,
  input  logic              step,
  seq_controle_if.master    bus,
  output logic [DATA_W-1:0] regA,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        estado,
  output logic              halted
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH      = 4'd1,
    FETCH_WAIT = 4'd2,
    DECODE     = 4'd3,
    MEM_READ   = 4'd4,
    MEM_WAIT   = 4'd5,
    EXECUTE    = 4'd6,
    STORE      = 4'd7,
    HALT       = 4'd8
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] rega_q, rega_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              rd_q, rd_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] endmem_q, endmem_d;
  logic              halted_q, halted_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operando;
  state_t            done_state;

  assign opcode     = ir_q[DATA_W-1 -: 4];
  assign operando   = ir_q[ADDR_W-1:0];
  assign done_state = run ? FETCH : IDLE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rega_d  = rega_q;
    mdr_d   = mdr_q;
    case (state_q)
      IDLE:       if (run || step) state_d = FETCH;
      FETCH:      state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        ir_d    = bus.dataOutMem;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = MEM_READ;
          OP_STA: state_d = STORE;
          OP_LDI: begin
            rega_d  = DATA_W'(operando);
            state_d = done_state;
          end
          OP_JMP: begin
            pc_d    = operando;
            state_d = done_state;
          end
          OP_JZ: begin
            if (rega_q == '0) pc_d = operando;
            state_d = done_state;
          end
          OP_HLT:  state_d = HALT;
          default: state_d = done_state;  // NOP and unused opcodes
        endcase
      end
      MEM_READ:   state_d = MEM_WAIT;
      MEM_WAIT: begin
        mdr_d   = bus.dataOutMem;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        rega_d  = (opcode == OP_LDA) ? mdr_q : bus.saidaULA;
        state_d = done_state;
      end
      STORE:      state_d = done_state;
      HALT:       state_d = HALT;
      default:    state_d = IDLE;
    endcase

    // Strobes and address are registered from the next state so they line up with it
    rd_d     = (state_d == FETCH) || (state_d == MEM_READ);
    we_d     = (state_d == STORE);
    halted_d = (state_d == HALT);
    if (state_d == FETCH)
      endmem_d = pc_d;
    else if ((state_d == MEM_READ) || (state_d == STORE))
      endmem_d = ir_d[ADDR_W-1:0];
    else
      endmem_d = '0;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      rega_q   <= '0;
      mdr_q    <= '0;
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      endmem_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      rega_q   <= rega_d;
      mdr_q    <= mdr_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      endmem_q <= endmem_d;
      halted_q <= halted_d;
    end
  end

  assign bus.endMem    = endmem_q;
  assign bus.rd        = rd_q;
  assign bus.we        = we_q;
  assign bus.dataInMem = rega_q;
  assign bus.ulaOpcode = opcode;
  assign bus.ulaA      = rega_q;
  assign bus.ulaB      = mdr_q;

  assign regA   = rega_q;
  assign pc     = pc_q;
  assign ir     = ir_q;
  assign estado = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_seq_controle.sv
// Scoreboard bench for seq_controle: directed programs, expected retirements and
// RAM stores queued by the stimulus and checked by an independent monitor.
module tb_seq_controle;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] regA;
  logic [3:0] pc;
  logic [7:0] ir;
  logic [3:0] estado;
  logic       halted;

  seq_controle_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  seq_controle #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock  (clock),
    .resetN (resetN),
    .run    (run),
    .step   (step),
    .bus    (bus),
    .regA   (regA),
    .pc     (pc),
    .ir     (ir),
    .estado (estado),
    .halted (halted)
  );

  always #5 clock = ~clock;

  // RAM model: registered read, write at clock edge; preloaded from prog while load=1
  logic [7:0] mem  [16];
  logic [7:0] prog [16];
  logic       load = 1'b0;

  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= prog[i];
    end else begin
      if (bus.we) mem[bus.endMem] <= bus.dataInMem;
      if (bus.rd) bus.dataOutMem <= mem[bus.endMem];
    end
  end

  // ULA model
  always_comb begin
    case (bus.ulaOpcode)
      4'h4:    bus.saidaULA = bus.ulaA + bus.ulaB;
      4'h5:    bus.saidaULA = bus.ulaA - bus.ulaB;
      4'h6:    bus.saidaULA = bus.ulaA & bus.ulaB;
      4'h7:    bus.saidaULA = bus.ulaA | bus.ulaB;
      default: bus.saidaULA = bus.ulaB;
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected retirements {pc,regA} and stores {addr,data}
  int ret_q[$];
  int sto_q[$];
  logic [3:0] prev_st = 4'd0;
  logic [3:0] last_exec_op = 4'd0;

  always @(negedge clock) begin
    if (!resetN) begin
      prev_st = 4'd0;
    end else begin
      if (bus.we) begin
        if (sto_q.size() == 0) check("store_unexpected", {bus.endMem, bus.dataInMem}, 0);
        else check("store", {bus.endMem, bus.dataInMem}, sto_q.pop_front());
        $display("store addr=%0d data=0x%02h", bus.endMem, bus.dataInMem);
      end
      if ((estado == 4'd0 || estado == 4'd1) &&
          (prev_st == 4'd3 || prev_st == 4'd6 || prev_st == 4'd7)) begin
        if (ret_q.size() == 0) check("retire_unexpected", {pc, regA}, 0);
        else check("retire", {pc, regA}, ret_q.pop_front());
        $display("retire pc=%0d regA=0x%02h", pc, regA);
      end
      if (estado == 4'd6) last_exec_op = bus.ulaOpcode;
      prev_st = estado;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    run = 1'b0;
    step = 1'b0;
    load = 1'b1;
    tick(2);
    load = 1'b0;
    ret_q.delete();
    sto_q.delete();
    resetN = 1'b1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic wait_halted(input int bound);
    int n = 0;
    while (!halted && n < bound) begin
      tick(1);
      n++;
    end
    check("halt_timeout", int'(halted), 1);
  endtask

  task automatic wait_state(input logic [3:0] s, input int bound);
    int n = 0;
    while (estado != s && n < bound) begin
      tick(1);
      n++;
    end
    check("state_timeout", int'(estado), int'(s));
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset / idle
    clear_prog();
    do_reset();
    tick(10);
    check("idle_state", int'(estado), 0);
    check("idle_pc", int'(pc), 0);
    check("idle_rd", int'(bus.rd), 0);
    check("idle_we", int'(bus.we), 0);
    check("idle_regA", int'(regA), 0);

    // LDI 5 / STA 10 / HLT
    clear_prog();
    prog[0] = 8'h35; prog[1] = 8'h2A; prog[2] = 8'hF0;
    do_reset();
    ret_q.push_back({4'd1, 8'h05});
    sto_q.push_back({4'd10, 8'h05});
    ret_q.push_back({4'd2, 8'h05});
    run = 1'b1;
    wait_halted(40);
    check("sta_mem10", int'(mem[10]), 8'h05);
    check("sta_pc", int'(pc), 3);
    check("sta_estado", int'(estado), 8);
    check("sta_rd_in_halt", int'(bus.rd), 0);
    check("sta_endmem_in_halt", int'(bus.endMem), 0);
    run = 1'b0;
    pulse_step();
    tick(5);
    check("halt_sticky", int'(estado), 8);
    check("sta_ret_left", ret_q.size(), 0);
    check("sta_sto_left", sto_q.size(), 0);

    // LDA 14 / ADD 15 with 8-bit wrap
    clear_prog();
    prog[0] = 8'h1E; prog[1] = 8'h4F; prog[2] = 8'hF0;
    prog[14] = 8'hF0; prog[15] = 8'h20;
    do_reset();
    ret_q.push_back({4'd1, 8'hF0});
    ret_q.push_back({4'd2, 8'h10});
    run = 1'b1;
    wait_halted(60);
    check("alu_regA", int'(regA), 8'h10);
    check("alu_opcode_exec", int'(last_exec_op), 4);
    check("alu_pc", int'(pc), 3);
    check("alu_ret_left", ret_q.size(), 0);

    // JZ taken, then JMP-to-self loop; run dropped mid-loop
    clear_prog();
    prog[0] = 8'h30; prog[1] = 8'h95; prog[5] = 8'h37; prog[6] = 8'h86;
    do_reset();
    ret_q.push_back({4'd1, 8'h00});
    ret_q.push_back({4'd5, 8'h00});
    ret_q.push_back({4'd6, 8'h07});
    for (int i = 0; i < 5; i++) ret_q.push_back({4'd6, 8'h07});
    run = 1'b1;
    begin
      int n = 0;
      while (ret_q.size() > 1 && n < 100) begin
        tick(1);
        n++;
      end
    end
    run = 1'b0;
    wait_state(4'd0, 20);
    tick(3);
    check("jmp_ret_left", ret_q.size(), 0);
    check("jmp_pc", int'(pc), 6);
    check("jmp_regA", int'(regA), 8'h07);

    // JZ not taken
    clear_prog();
    prog[0] = 8'h31; prog[1] = 8'h95; prog[2] = 8'hF0;
    do_reset();
    ret_q.push_back({4'd1, 8'h01});
    ret_q.push_back({4'd2, 8'h01});
    run = 1'b1;
    wait_halted(40);
    check("jz_nt_pc", int'(pc), 3);
    check("jz_nt_ret_left", ret_q.size(), 0);

    // Step mode: one instruction per pulse, step during DECODE ignored
    clear_prog();
    prog[0] = 8'h31; prog[1] = 8'h32; prog[2] = 8'h33;
    do_reset();
    ret_q.push_back({4'd1, 8'h01});
    ret_q.push_back({4'd2, 8'h02});
    ret_q.push_back({4'd3, 8'h03});
    tick(3);
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      if (i == 1) begin
        wait_state(4'd3, 10);
        pulse_step();
      end
      tick(10);
      check("step_pc", int'(pc), i + 1);
      check("step_idle", int'(estado), 0);
    end
    check("step_ret_left", ret_q.size(), 0);

    // Async reset during STORE
    clear_prog();
    prog[0] = 8'h35; prog[1] = 8'h2A; prog[2] = 8'hF0;
    do_reset();
    ret_q.push_back({4'd1, 8'h05});
    run = 1'b1;
    begin
      int n = 0;
      while (estado != 4'd7 && n < 40) begin
        @(posedge clock);
        #1;
        n++;
      end
    end
    check("store_reached", int'(estado), 7);
    check("store_we_high", int'(bus.we), 1);
    resetN = 1'b0;
    #1;
    check("arst_we", int'(bus.we), 0);
    check("arst_state", int'(estado), 0);
    check("arst_pc", int'(pc), 0);
    check("arst_regA", int'(regA), 0);
    check("arst_ir", int'(ir), 0);
    check("arst_endmem", int'(bus.endMem), 0);
    tick(2);
    check("arst_mem10", int'(mem[10]), 0);
    ret_q.delete();
    sto_q.delete();
    ret_q.push_back({4'd1, 8'h05});
    sto_q.push_back({4'd10, 8'h05});
    ret_q.push_back({4'd2, 8'h05});
    resetN = 1'b1;
    wait_halted(40);
    check("arst_rerun_mem10", int'(mem[10]), 8'h05);
    check("arst_rerun_pc", int'(pc), 3);
    check("arst_ret_left", ret_q.size() + sto_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
